// File: rtl/ppi8255.sv
`timescale 1ns/1ps
// ppi8255 - mode-0 parallel peripheral interface (i8255 / KR580VV55 subset).
//
// Three 8-bit ports with programmable direction, per-port output latches,
// port C bit set/reset and a registered CPU read path.
//
// Write handshake: a register write happens once per rising edge of the
// qualified level strobe (ce & wr). The strobe may stay high for any number of
// cycles and still produce exactly one update. To write again it must drop for
// at least one cycle.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ce, rd, wr          chip select, read strobe and write strobe (levels)
//   a[1:0]              register select: 0=PA, 1=PB, 2=PC, 3=control
//   idata[7:0]          CPU write data
//   odata[7:0]          CPU read data, registered; 8'hFF when not reading
//   pa_i, pb_i, pc_i    port input pins
//   pa_o, pb_o, pc_o    port output pins (an input-mode port idles high)
module ppi8255 #(
  parameter logic [7:0] RESET_CW = 8'h9B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] a,
  input  logic [7:0] idata,
  output logic [7:0] odata,
  input  logic [7:0] pa_i,
  input  logic [7:0] pb_i,
  input  logic [7:0] pc_i,
  output logic [7:0] pa_o,
  output logic [7:0] pb_o,
  output logic [7:0] pc_o
);

  logic [7:0] cw;
  logic [7:0] la, lb, lc;
  logic [7:0] sa, sb, sc;
  logic       wr_q;
  logic       wr_fire;
  logic [7:0] readval;

  // Direction bits of the control word (1 = input).
  logic pa_in, pb_in, pch_in, pcl_in;
  assign pa_in  = cw[4];
  assign pb_in  = cw[1];
  assign pch_in = cw[3];
  assign pcl_in = cw[0];

  assign wr_fire = ce & wr & ~wr_q;

  assign pa_o       = pa_in  ? 8'hFF : la;
  assign pb_o       = pb_in  ? 8'hFF : lb;
  assign pc_o[7:4]  = pch_in ? 4'hF  : lc[7:4];
  assign pc_o[3:0]  = pcl_in ? 4'hF  : lc[3:0];

  // Read value uses pre-write state, so a simultaneous read and write returns
  // the old contents in that cycle.
  always_comb begin
    readval = 8'hFF;
    case (a)
      2'd0: readval = pa_in ? sa : la;
      2'd1: readval = pb_in ? sb : lb;
      2'd2: begin
        readval[7:4] = pch_in ? sc[7:4] : lc[7:4];
        readval[3:0] = pcl_in ? sc[3:0] : lc[3:0];
      end
      default: readval = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw    <= RESET_CW;
      la    <= 8'h00;
      lb    <= 8'h00;
      lc    <= 8'h00;
      sa    <= 8'hFF;
      sb    <= 8'hFF;
      sc    <= 8'hFF;
      wr_q  <= 1'b0;
      odata <= 8'hFF;
    end else begin
      wr_q  <= ce & wr;
      sa    <= pa_i;
      sb    <= pb_i;
      sc    <= pc_i;
      odata <= (ce & rd) ? readval : 8'hFF;
      if (wr_fire) begin
        case (a)
          2'd0: la <= idata;
          2'd1: lb <= idata;
          2'd2: lc <= idata;
          default: begin
            if (idata[7]) begin
              // Mode set: new directions, all latches cleared.
              cw <= idata;
              la <= 8'h00;
              lb <= 8'h00;
              lc <= 8'h00;
            end else begin
              // Port C bit set/reset, regardless of nibble direction.
              lc[idata[3:1]] <= idata[0];
            end
          end
        endcase
      end
    end
  end

endmodule
